uart_word_tx: RTL and testbench

//  Serial transmitter paired with the shared prescaler: sends a 32-bit word as up to

---
 rtl/uart_word_tx.sv | 131 +++++++++++++
 tb/tb_uart_word_tx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// rtl/uart_word_tx.sv - 32-bit word to up-to-four 8N1 UART bytes, byte 0 first, masked bytes skipped
module uart_word_tx #(
  parameter int TICKS_PER_BIT = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        scaled,
  input  logic        send,
  input  logic [31:0] wrdata,
  input  logic [3:0]  byte_mask,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int CW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, NEXT} state_t;

  state_t        state, state_nx;
  logic [31:0]   word_q, word_nx;
  logic [3:0]    mask_q, mask_nx;
  logic [2:0]    idx_q, idx_nx;
  logic [7:0]    shift_q, shift_nx;
  logic [2:0]    bit_q, bit_nx;
  logic [CW-1:0] tick_q, tick_nx;
  logic          tx_nx;
  logic          bit_end;
  logic          found;
  logic [1:0]    sel;

  // Lowest unmasked byte at or after the current index; all skipped bytes collapse into one NEXT clock.
  always_comb begin
    found = 1'b0;
    sel   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (3'(i) >= idx_q && !mask_q[i]) begin
        found = 1'b1;
        sel   = 2'(i);
      end
    end
  end

  assign bit_end = scaled && (tick_q == CW'(TICKS_PER_BIT - 1));

  always_comb begin
    state_nx = state;
    word_nx  = word_q;
    mask_nx  = mask_q;
    idx_nx   = idx_q;
    shift_nx = shift_q;
    bit_nx   = bit_q;
    tick_nx  = '0;
    done     = 1'b0;
    if (state == START || state == DATA || state == STOP) begin
      tick_nx = tick_q;
      if (scaled) tick_nx = bit_end ? '0 : tick_q + CW'(1);
    end
    case (state)
      IDLE: begin
        if (send) begin
          word_nx  = wrdata;
          mask_nx  = byte_mask;
          idx_nx   = 3'd0;
          state_nx = NEXT;
        end
      end
      NEXT: begin
        bit_nx = 3'd0;
        if (!found) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else begin
          idx_nx   = {1'b0, sel};
          shift_nx = word_q[{sel, 3'b000} +: 8];
          state_nx = START;
        end
      end
      START: if (bit_end) state_nx = DATA;
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_nx = STOP;
          end else begin
            shift_nx = shift_q >> 1;
            bit_nx   = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          idx_nx   = idx_q + 3'd1;
          state_nx = NEXT;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // tx follows the state being entered so the pin is driven straight from a flop.
  always_comb begin
    tx_nx = 1'b1;
    if (state_nx == START) tx_nx = 1'b0;
    else if (state_nx == DATA) tx_nx = shift_nx[0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      word_q  <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      tick_q  <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nx;
      word_q  <= word_nx;
      mask_q  <= mask_nx;
      idx_q   <= idx_nx;
      shift_q <= shift_nx;
      bit_q   <= bit_nx;
      tick_q  <= tick_nx;
      tx      <= tx_nx;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_word_tx.sv
// tb/tb_uart_word_tx.sv - scoreboard bench: tick-counting UART receiver model decodes tx against queued bytes
module tb_uart_word_tx;

  logic        clock = 1'b0;
  logic        reset_n, scaled, send;
  logic [31:0] wrdata;
  logic [3:0]  byte_mask;
  logic        tx, busy, done;
  logic        scaled2, send2;
  logic [31:0] wrdata2;
  logic [3:0]  mask2;
  logic        tx2, busy2, done2;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int scaled_mode = 0;
  int cnt3 = 0;
  logic [7:0] exp_q[$];
  logic tx_tr[0:4095];
  logic busy_tr[0:4095];
  logic done_tr[0:4095];
  logic t2[0:4095];

  always #5 clock = ~clock;

  uart_word_tx #(.TICKS_PER_BIT(1)) dut (
    .clock(clock), .reset_n(reset_n), .scaled(scaled), .send(send),
    .wrdata(wrdata), .byte_mask(byte_mask), .tx(tx), .busy(busy), .done(done)
  );

  uart_word_tx #(.TICKS_PER_BIT(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .scaled(scaled2), .send(send2),
    .wrdata(wrdata2), .byte_mask(mask2), .tx(tx2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Prescaler ticks, changed just after each rising edge.
  always @(posedge clock) begin
    #1;
    scaled  = (scaled_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    scaled2 = (cnt3 == 2);
    cnt3    = (cnt3 + 1) % 3;
  end

  // Receiver model: a frame starts at the first low line; each bit lasts one tick (TPB=1 DUT).
  bit         in_frame = 0;
  int         bitn = 0;
  int         tcnt = 0;
  logic [9:0] frm;
  always @(negedge clock) begin
    if (done === 1'b1) done_cnt++;
    if (!reset_n) begin
      in_frame = 0;
    end else begin
      if (!in_frame && tx === 1'b0) begin
        in_frame = 1; bitn = 0; tcnt = 0;
      end
      if (in_frame && scaled) begin
        tcnt++;
        if (tcnt == 1) begin
          tcnt = 0;
          frm[bitn] = tx;
          bitn++;
          if (bitn == 10) begin
            in_frame = 0;
            chk("framing", {frm[9], frm[0]}, 2'b10);
            if (exp_q.size() == 0) begin
              total++; bad++;
              $display("FAIL unexpected_byte: got %0h want none", frm[8:1]);
            end else begin
              chk("byte", frm[8:1], exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic [3:0] m, input bit interfere, output int k);
    int g, d0;
    g = 0;
    while (busy && g < 5000) begin @(posedge clock); g++; end
    @(posedge clock); #1;
    d0 = done_cnt;
    send = 1'b1; wrdata = d; byte_mask = m;
    for (int i = 0; i < 4; i++) if (!m[i]) exp_q.push_back(d[8*i +: 8]);
    @(posedge clock); #1;
    send = 1'b0; wrdata = $urandom; byte_mask = 4'($urandom);
    k = 0;
    do begin
      @(negedge clock);
      k++;
      tx_tr[k] = tx; busy_tr[k] = busy; done_tr[k] = done;
      if (interfere && k >= 5) begin send = 1'b1; wrdata = ~d; byte_mask = 4'h0; end
    end while (!done && k < 4000);
    chk("done_seen", 32'(done), 1);
    @(negedge clock);
    tx_tr[k+1] = tx; busy_tr[k+1] = busy; done_tr[k+1] = done;
    send = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("done_count", done_cnt - d0, 1);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int k, ones, p, s, len;
    logic [7:0] val;
    logic [31:0] w;
    logic [9:0] pat;
    reset_n = 1'b0; send = 1'b0; wrdata = '0; byte_mask = '0;
    send2 = 1'b0; wrdata2 = '0; mask2 = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_tx", 32'(tx), 1);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);

    // Single byte A5, bytes 1..3 masked: exact tx waveform and done timing.
    send_word(32'h0000_00A5, 4'hE, 0, k);
    chk("a5_done_cycle", k, 12);
    pat = 10'b11_0100_1010;
    chk("a5_next_tx", 32'(tx_tr[1]), 1);
    for (int i = 0; i < 10; i++) chk("a5_tx_bit", 32'(tx_tr[2+i]), 32'(pat[i]));
    chk("a5_done_tx", 32'(tx_tr[12]), 1);
    chk("a5_busy_at_done", 32'(busy_tr[12]), 1);
    chk("a5_busy_after", 32'(busy_tr[13]), 0);
    chk("a5_done_after", 32'(done_tr[13]), 0);

    // Full word, nothing masked.
    send_word(32'h4433_2211, 4'h0, 0, k);
    chk("full_done_cycle", k, 45);
    ones = 0;
    for (int i = 1; i <= k; i++) ones += int'(busy_tr[i]);
    chk("full_busy_high", ones, k);
    chk("full_busy_low", 32'(busy_tr[k+1]), 0);

    // Everything masked: no frame at all.
    send_word($urandom, 4'hF, 0, k);
    chk("maskf_done_cycle", k, 1);
    ones = 0;
    for (int i = 1; i <= k + 1; i++) ones += int'(busy_tr[i]);
    chk("maskf_busy_le4", 32'(ones <= 4), 1);
    ones = 0;
    for (int i = 1; i <= k + 1; i++) ones += int'(!tx_tr[i]);
    chk("maskf_tx_never_low", ones, 0);

    // send held high while busy and at done is ignored.
    send_word(32'h8765_4321, 4'h0, 1, k);
    chk("ignore_busy_low", 32'(busy_tr[k+1]), 0);

    // Random words, masks and prescaler pattern.
    scaled_mode = 1;
    for (int n = 0; n < 10; n++) begin
      send_word($urandom, 4'($urandom), 0, k);
    end
    scaled_mode = 0;

    // Async reset in the middle of byte 1's data bits, then restart from byte 0.
    w = $urandom;
    @(posedge clock); #1;
    send = 1'b1; wrdata = w; byte_mask = 4'h0;
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
    @(posedge clock); #1;
    send = 1'b0;
    repeat (15) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_tx", 32'(tx), 1);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_byte0_sent", exp_q.size(), 3);
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    send_word(32'hCAFE_F00D, 4'h0, 0, k);
    chk("rst_restart_cycle", k, 45);

    // TPB=4 with a tick every third clock: 12 clocks per bit.
    @(posedge clock); #1;
    send2 = 1'b1; wrdata2 = {24'($urandom), 8'h55}; mask2 = 4'hE;
    @(posedge clock); #1;
    send2 = 1'b0;
    k = 0;
    do begin
      @(negedge clock);
      k++;
      t2[k] = tx2;
    end while (!done2 && k < 4000);
    chk("tpb4_done_seen", 32'(done2), 1);
    s = 1;
    while (s < k && t2[s]) s++;
    p = s;
    while (p < k && !t2[p]) p++;
    val = '0;
    for (int r = 0; r < 8; r++) begin
      len = 0;
      val[r] = t2[p];
      while (p < k && t2[p] == val[r]) begin len++; p++; end
      chk("tpb4_bit_len", len, 12);
    end
    chk("tpb4_stop_len", k - p, 12);
    chk("tpb4_byte", val, 8'h55);

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
